demux_1x2_32bit_buf: RTL and testbench
======================================

Name: demux_1x2_32bit_buf

Overview:
Buffered 1-to-2 demultiplexer. It is the steering counterpart of mux_2x1_32bit: it routes one 32-bit input stream to one of two output streams, selected by SELECT. Each output lane has a small FIFO with valid/ready handshake, so a stalled consumer on one lane does not block the other lane. It sits between a single producer (e.g. writeback/forwarding source) and two independent consumers in the datapath.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 2, entries per output lane FIFO; power of two, minimum 2

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET_N  input  1  asynchronous active-low reset
IN_DATA  input  WIDTH  input word
IN_VALID  input  1  producer has a word on IN_DATA
SELECT  input  1  destination lane: 0 = lane 0, 1 = lane 1; sampled with IN_DATA
IN_READY  output  1  selected lane can accept a word this cycle
OUT0_DATA  output  WIDTH  head word of lane 0
OUT0_VALID  output  1  lane 0 non-empty
OUT0_READY  input  1  lane 0 consumer accepts head
OUT1_DATA  output  WIDTH  head word of lane 1
OUT1_VALID  output  1  lane 1 non-empty
OUT1_READY  input  1  lane 1 consumer accepts head

Behaviour:
- Interface decision: one clock, CLK. Reset is RESET_N, asynchronous, active-low.
- Reset, asserted at any time including mid-transfer:
  - Both lanes flush immediately; pointers and counts go to 0.
  - OUT0_VALID = OUT1_VALID = 0 and OUT0_DATA = OUT1_DATA = 0.
  - IN_READY = 1.
- Input transfer: occurs on a rising edge when IN_VALID && IN_READY. The word is written to lane SELECT.
- IN_READY = !full[SELECT].
  - Combinational from SELECT and the registered full flags only.
  - No combinational path from OUTx_READY to IN_READY.
- Output transfer on lane x: occurs on a rising edge when OUTx_VALID && OUTx_READY. The head word is popped.
- OUTx_VALID = (count_x != 0).
- OUTx_DATA = head entry when OUTx_VALID = 1; forced to 0 when OUTx_VALID = 0.
- Latency: a word accepted at edge k is visible on OUTx with OUTx_VALID = 1 in the cycle after edge k, i.e. 1 cycle. There is no fall-through in the same cycle.
- Ordering: strict FIFO order per lane. No ordering relation between lanes.
- Pointers: width log2(DEPTH). Wrap from DEPTH-1 to 0. count_x width log2(DEPTH)+1.
- Full lane (count = DEPTH):
  - IN_READY is low while SELECT addresses it, even if the same lane pops this cycle.
  - Switching SELECT to a non-full lane raises IN_READY in the same cycle.
- Empty lane: OUTx_READY has no effect; count never underflows.
- Simultaneous push and pop on the same non-full, non-empty lane: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty lane: pop ignored, push taken, count becomes 1.
- Push to one lane while the other pops: fully independent.
- Producer rule: while IN_VALID = 1 and IN_READY = 0, IN_DATA and SELECT are held stable. The bench checks this with an assertion; the RTL does not enforce it.
- IN_VALID = 0: no state change on the input side, whatever SELECT is.

Decomposition:
- Shared package (demux_pkg):
  - DEMUX_WIDTH_DEFAULT = 32
  - DEMUX_DEPTH_DEFAULT = 2
  - LANE0 = 1'b0, LANE1 = 1'b1
- Sub-module demux_lane_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports CLK, RESET_N, PUSH, PUSH_DATA, POP, FULL, EMPTY, HEAD_DATA.
  - Instantiated twice.
- The top level holds only steering logic: push enables, IN_READY select, and output data gating.

Test Plan:
1. Reset, then IN_VALID=1, SELECT=0, IN_DATA=0xDEADBEEF, OUT0_READY=0 for one edge -> next cycle OUT0_VALID=1, OUT0_DATA=0xDEADBEEF; OUT1_VALID=0, OUT1_DATA=0.
2. Fill lane 1 with 0x11111111 and 0x22222222, OUT1_READY=0 -> IN_READY=0 while SELECT=1. Flip SELECT=0 -> IN_READY=1 in the same cycle. Raise OUT1_READY -> pops 0x11111111, then 0x22222222, in order.
3. Lane 0 holding 1 word, simultaneous push 0xA5A5A5A5 and pop on lane 0 -> count stays 1, head becomes 0xA5A5A5A5.
4. Alternating SELECT 0,1,0,1 with data 1,2,3,4, both READY=1 continuously -> lane 0 emits 1,3 and lane 1 emits 2,4, one word per cycle, 1-cycle latency each.
5. Lane 0 stalled and full (DEPTH=2) while lane 1 streams 0x100..0x10F with OUT1_READY=1 -> all 16 words delivered on lane 1, none lost; lane 0 contents unchanged.
6. RESET_N pulsed low asynchronously (mid-cycle) with both lanes full -> OUTx_VALID and OUTx_DATA go to 0 immediately, IN_READY=1; after release, a fresh push of 0x5 appears alone on the selected lane.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer.
//   DEMUX_WIDTH_DEFAULT : default data word width
//   DEMUX_DEPTH_DEFAULT : default entries per output lane FIFO
//   LANE0 / LANE1       : encodings of the select input
package demux_pkg;

    localparam int unsigned DEMUX_WIDTH_DEFAULT = 32;
    localparam int unsigned DEMUX_DEPTH_DEFAULT = 2;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_lane_fifo.sv
// Single output lane of the demultiplexer: a small synchronous FIFO.
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset, flushes the lane
//   push      : write push_data this edge (ignored while full)
//   push_data : word to write
//   pop       : drop the head entry this edge (ignored while empty)
//   full      : count == DEPTH (registered)
//   empty     : count == 0 (registered)
//   head_data : oldest stored word; meaningless while empty
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module demux_lane_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem[rd_ptr_q];

    // Guard against overflow/underflow locally so the lane is safe on its own.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/demux_1x2_32bit_buf.sv
// Buffered 1-to-2 demultiplexer: steers one valid/ready input stream into one
// of two independently buffered output lanes chosen by select.
// Ports:
//   clk, reset_n           : clock and asynchronous active-low reset
//   in_data/in_valid       : producer word and valid
//   select                 : destination lane (0 = lane 0, 1 = lane 1)
//   in_ready               : selected lane has room (registered full flag only)
//   out0_data/valid/ready  : lane 0 output handshake, data zero when not valid
//   out1_data/valid/ready  : lane 1 output handshake, data zero when not valid
module demux_1x2_32bit_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH_DEFAULT,
    parameter int unsigned DEPTH = DEMUX_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             select,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
);

    logic             full0, full1;
    logic             empty0, empty1;
    logic [WIDTH-1:0] head0, head1;
    logic             push0, push1;
    logic             in_fire;

    // Only registered full flags feed in_ready, so a pop on the addressed lane
    // cannot open it in the same cycle and out*_ready never reaches in_ready.
    assign in_ready = (select == LANE1) ? !full1 : !full0;
    assign in_fire  = in_valid && in_ready;
    assign push0    = in_fire && (select == LANE0);
    assign push1    = in_fire && (select == LANE1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign out0_data  = out0_valid ? head0 : '0;
    assign out1_data  = out1_valid ? head1 : '0;

    demux_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0),
        .empty     (empty0),
        .head_data (head0)
    );

    demux_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lane1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1),
        .empty     (empty1),
        .head_data (head1)
    );

endmodule

// File: tb/tb_demux_1x2_32bit_buf.sv
module tb_demux_1x2_32bit_buf;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        select;
    logic        in_ready;
    logic [31:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;

    int errors = 0;
    int checks = 0;

    demux_1x2_32bit_buf #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .select     (select),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Producer rule: a stalled request must hold data and select stable.
    logic        stall_q = 1'b0;
    logic [31:0] data_q  = '0;
    logic        sel_q   = 1'b0;
    always @(posedge clk) begin
        if (reset_n && stall_q && in_valid) begin
            assert (in_data == data_q && select == sel_q)
                else $error("producer changed a stalled request");
        end
        stall_q <= reset_n && in_valid && !in_ready;
        data_q  <= in_data;
        sel_q   <= select;
    end

    initial begin
        reset_n    = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        select     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data", out0_data, 32'd0);
        check("rst_out1_data", out1_data, 32'd0);
        #5;
        reset_n = 1'b1;

        // 1: single push to lane 0, visible the cycle after acceptance.
        in_valid = 1'b1; select = 1'b0; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        check("t1_out0_valid", 32'(out0_valid), 32'd1);
        check("t1_out0_data", out0_data, 32'hDEADBEEF);
        check("t1_out1_valid", 32'(out1_valid), 32'd0);
        check("t1_out1_data", out1_data, 32'd0);
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        check("t1_drained_valid", 32'(out0_valid), 32'd0);
        check("t1_drained_data", out0_data, 32'd0);

        // 2: fill lane 1, in_ready follows select, ordered drain.
        in_valid = 1'b1; select = 1'b1; in_data = 32'h11111111;
        tick();
        in_data = 32'h22222222;
        tick();
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        check("t2_head", out1_data, 32'h11111111);
        in_valid = 1'b0;
        out1_ready = 1'b1;
        #1;
        check("t2_full_pop_in_ready", 32'(in_ready), 32'd0);
        select = 1'b0;
        #1;
        check("t2_switch_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("t2_pop1_valid", 32'(out1_valid), 32'd1);
        check("t2_pop1_data", out1_data, 32'h22222222);
        tick();
        check("t2_pop2_valid", 32'(out1_valid), 32'd0);
        out1_ready = 1'b0;

        // 3: simultaneous push/pop on a lane holding one word.
        in_valid = 1'b1; select = 1'b0; in_data = 32'h00000033;
        tick();
        in_data = 32'hA5A5A5A5; out0_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_valid", 32'(out0_valid), 32'd1);
        check("t3_head", out0_data, 32'hA5A5A5A5);
        tick();
        check("t3_one_entry", 32'(out0_valid), 32'd0);
        // Push and pop on an empty lane: pop ignored, word kept.
        in_valid = 1'b1; in_data = 32'h00000077;
        tick();
        in_valid = 1'b0;
        check("t3_empty_pushpop_valid", 32'(out0_valid), 32'd1);
        check("t3_empty_pushpop_data", out0_data, 32'h00000077);
        tick();
        check("t3_empty_after", 32'(out0_valid), 32'd0);

        // 4: alternating lanes, both consumers always ready.
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; select = i[0]; in_data = 32'(i + 1);
            tick();
            if (i[0]) begin
                check("t4_lane1_data", out1_data, 32'(i + 1));
                check("t4_lane0_idle", 32'(out0_valid), 32'd0);
            end else begin
                check("t4_lane0_data", out0_data, 32'(i + 1));
                check("t4_lane1_idle", 32'(out1_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        check("t4_all_empty", 32'({out0_valid, out1_valid}), 32'd0);

        // 5: lane 0 stalled full, lane 1 streams independently.
        out0_ready = 1'b0;
        in_valid = 1'b1; select = 1'b0; in_data = 32'h000000A0;
        tick();
        in_data = 32'h000000A1;
        tick();
        select = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 32'h100 + 32'(i);
            #1;
            check("t5_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("t5_lane1_data", out1_data, 32'h100 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("t5_lane1_done", 32'(out1_valid), 32'd0);
        check("t5_lane0_head", out0_data, 32'h000000A0);
        select = 1'b0;
        #1;
        check("t5_lane0_full", 32'(in_ready), 32'd0);

        // 6: both lanes full, asynchronous mid-cycle reset.
        out1_ready = 1'b0;
        in_valid = 1'b1; select = 1'b1; in_data = 32'h000000B0;
        tick();
        in_data = 32'h000000B1;
        tick();
        in_valid = 1'b0;
        check("t6_pre_full", 32'(in_ready), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_out0_valid", 32'(out0_valid), 32'd0);
        check("t6_rst_out0_data", out0_data, 32'd0);
        check("t6_rst_out1_valid", 32'(out1_valid), 32'd0);
        check("t6_rst_out1_data", out1_data, 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        reset_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h00000005;
        tick();
        in_valid = 1'b0;
        check("t6_fresh_valid", 32'(out1_valid), 32'd1);
        check("t6_fresh_data", out1_data, 32'h00000005);
        check("t6_other_lane", 32'(out0_valid), 32'd0);
        out1_ready = 1'b1;
        tick();
        check("t6_alone", 32'(out1_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
